// File: rtl/ecc_host_if.sv
// ecc_host_if: host-side driver for the ECC scalar-multiply core.
// Accepts a W-bit scalar as a stream of BW-bit words (LSW first), pulses the
// core reset, enables the core until it reports completion, captures dx/dy
// and streams them back out as 2*NW words (dx LSW first, then dy LSW first).
// Optional feature macro: ECC_TIMEOUT_EN. When it is defined, RUN is bounded
// by TIMEOUT cycles and a timeout raises the sticky err flag.
//
// Handshake: a word moves on a stream port only in a cycle where both valid
// and ready are high at the rising clock edge; the source holds data/valid
// stable until it is taken, and the block never withdraws m_valid or changes
// m_data while m_ready is low.
module ecc_host_if #(
    parameter int W       = 163,
    parameter int BW      = 32,
    parameter int RST_CYC = 2,
    parameter int TIMEOUT = 200000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [BW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [BW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic          busy,
    output logic          err,
    output logic          ecc_rst,
    output logic          ecc_enable,
    output logic [W-1:0]  ecc_din,
    input  logic [W-1:0]  ecc_dx,
    input  logic [W-1:0]  ecc_dy,
    input  logic          ecc_done
);

    localparam int NW      = (W + BW - 1) / BW;
    localparam int CNT_MAX = (2 * NW > RST_CYC) ? 2 * NW : RST_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CLR    = 3'd2,
        S_RUN    = 3'd3,
        S_UNLOAD = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    res_x;
    logic [W-1:0]    res_y;
    logic            seen_low;
    logic            done_ok;
    logic            timeout_hit;
    logic [W-1:0]    word_mask;
    logic [W-1:0]    word_ins;
    logic [BW-1:0]   word_sel;

    // A done level only counts once it has been seen low during this RUN,
    // so a done left high by the previous operation cannot end this one.
    assign done_ok = (state == S_RUN) && ecc_done && seen_low;

`ifdef ECC_TIMEOUT_EN
    localparam int RW = $clog2(TIMEOUT + 1);
    logic [RW-1:0] run_cnt;
    logic          err_q;

    assign timeout_hit = (state == S_RUN) && !done_ok && (run_cnt == RW'(TIMEOUT - 1));

    // RUN cycle counter, cleared whenever the core is not running.
    always_ff @(posedge clk) begin
        if (rst || state != S_RUN) begin
            run_cnt <= '0;
        end else begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

    // Sticky timeout flag; cleared when the next scalar starts loading.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == S_IDLE && s_valid) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q && !rst;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (s_valid) state_nx = S_LOAD;
            end
            S_LOAD: begin
                if (s_valid && cnt == CW'(NW - 1)) state_nx = S_CLR;
            end
            S_CLR: begin
                if (cnt == CW'(RST_CYC - 1)) state_nx = S_RUN;
            end
            S_RUN: begin
                if (done_ok) begin
                    state_nx = S_UNLOAD;
                end else if (timeout_hit) begin
                    state_nx = S_IDLE;
                end
            end
            S_UNLOAD: begin
                if (m_ready && cnt == CW'(2 * NW - 1)) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Output decode; everything is forced to its reset value while rst is high.
    always_comb begin
        s_ready    = !rst && (state == S_IDLE || state == S_LOAD);
        m_valid    = !rst && (state == S_UNLOAD);
        m_last     = m_valid && (cnt == CW'(2 * NW - 1));
        m_data     = m_valid ? word_sel : '0;
        busy       = !rst && (state != S_IDLE);
        ecc_enable = !rst && (state == S_RUN);
        ecc_rst    = rst || (state == S_CLR);
    end

    // Placement of the incoming word at slot cnt; bits beyond W fall off the shift.
    always_comb begin
        word_mask = {{(W - BW){1'b0}}, {BW{1'b1}}} << (32'(cnt) * BW);
        word_ins  = {{(W - BW){1'b0}}, s_data} << (32'(cnt) * BW);
    end

    // Outgoing word: dx slots first, then dy slots; zero-fill above W.
    always_comb begin
        if (cnt < CW'(NW)) begin
            word_sel = BW'(res_x >> (32'(cnt) * BW));
        end else begin
            word_sel = BW'(res_y >> (32'(cnt - CW'(NW)) * BW));
        end
    end

    // Datapath: scalar assembly, CLR timing, result capture and unload counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            ecc_din  <= '0;
            res_x    <= '0;
            res_y    <= '0;
            seen_low <= 1'b0;
        end else begin
            seen_low <= (state == S_RUN) && (seen_low || !ecc_done);
            case (state)
                S_IDLE: begin
                    if (s_valid) begin
                        ecc_din <= {{(W - BW){1'b0}}, s_data};
                        cnt     <= CW'(1);
                    end
                end
                S_LOAD: begin
                    if (s_valid) begin
                        ecc_din <= (ecc_din & ~word_mask) | (word_ins & word_mask);
                        cnt     <= (cnt == CW'(NW - 1)) ? '0 : cnt + 1'b1;
                    end
                end
                S_CLR: begin
                    cnt <= (cnt == CW'(RST_CYC - 1)) ? '0 : cnt + 1'b1;
                end
                S_RUN: begin
                    if (done_ok) begin
                        res_x <= ecc_dx;
                        res_y <= ecc_dy;
                    end
                    cnt <= '0;
                end
                S_UNLOAD: begin
                    if (m_ready) begin
                        cnt <= (cnt == CW'(2 * NW - 1)) ? '0 : cnt + 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_host_if.sv
// tb_ecc_host_if: directed bench for ecc_host_if. The bench plays the role of
// both the host stream and the ECC core (it drives ecc_done/ecc_dx/ecc_dy).
module tb_ecc_host_if;

    localparam int W  = 163;
    localparam int BW = 32;
    localparam int NW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [BW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [BW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          busy;
    logic          err;
    logic          ecc_rst;
    logic          ecc_enable;
    logic [W-1:0]  ecc_din;
    logic [W-1:0]  ecc_dx;
    logic [W-1:0]  ecc_dy;
    logic          ecc_done;

    int checks = 0;
    int errors = 0;
    logic [BW-1:0] exp_q[$];
    logic [W-1:0]  din_hold;

    // Clock / reset block
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    ecc_host_if #(.W(W), .BW(BW), .RST_CYC(2), .TIMEOUT(50)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .err(err),
        .ecc_rst(ecc_rst), .ecc_enable(ecc_enable), .ecc_din(ecc_din),
        .ecc_dx(ecc_dx), .ecc_dy(ecc_dy), .ecc_done(ecc_done)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Scoreboard feed: six words of a padded operand, LSW first.
    task automatic push_words(input logic [191:0] v);
        for (int k = 0; k < NW; k++) exp_q.push_back(v[k*32 +: 32]);
    endtask

    // Driver: stream six scalar words, then follow CLR into the first RUN cycle.
    task automatic load_scalar(input logic [191:0] words, input int max_gap, input logic [W-1:0] exp_din);
        for (int k = 0; k < NW; k++) begin
            int gap;
            int n;
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            s_valid = 1'b0;
            repeat (gap) tick();
            s_valid = 1'b1;
            s_data  = words[k*32 +: 32];
            n = 0;
            while (!s_ready && n < 50) begin
                tick();
                n++;
            end
            if (n >= 50) chk("load_wait_s_ready", s_ready, 1);
            tick();
        end
        s_valid = 1'b0;
        s_data  = '0;
        chk("clr_s_ready", s_ready, 0);
        chk("clr_ecc_rst", ecc_rst, 1);
        chk("clr_enable", ecc_enable, 0);
        chk("clr_busy", busy, 1);
        chk("ecc_din", ecc_din, exp_din);
        tick();
        chk("clr2_ecc_rst", ecc_rst, 1);
        chk("clr2_enable", ecc_enable, 0);
        tick();
        chk("run_enable", ecc_enable, 1);
        chk("run_ecc_rst", ecc_rst, 0);
    endtask

    // Core model: done low for low_cycles, then present dx/dy with done high.
    task automatic finish_run(input logic [W-1:0] dx, input logic [W-1:0] dy, input int low_cycles);
        ecc_done = 1'b0;
        repeat (low_cycles) begin
            chk("run_no_mvalid", m_valid, 0);
            tick();
        end
        ecc_dx   = dx;
        ecc_dy   = dy;
        ecc_done = 1'b1;
        tick();
        chk("done_to_mvalid", m_valid, 1);
        chk("unload_enable", ecc_enable, 0);
        ecc_dx = 163'h0BAD_0BAD;
        ecc_dy = 163'h0BAD_0BAD;
    endtask

    // Sink: mode 0 always ready, mode 1 ready pattern 1-0-0-1.
    task automatic unload(input int mode);
        int got;
        int cyc;
        logic stalled;
        logic [BW-1:0] held;
        got = 0;
        cyc = 0;
        stalled = 1'b0;
        held = '0;
        while (got < 2 * NW && cyc < 300) begin
            m_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (stalled) begin
                chk("stall_data", m_data, held);
                chk("stall_valid", m_valid, 1);
            end
            if (m_valid) begin
                if (m_ready) begin
                    chk("m_data", m_data, exp_q.pop_front());
                    chk("m_last", m_last, (got == 2 * NW - 1));
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = m_data;
                end
            end
            tick();
            cyc++;
        end
        m_ready = 1'b0;
        chk("unload_count", got, 2 * NW);
        chk("idle_mvalid", m_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_s_ready", s_ready, 1);
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        ecc_dx = '0; ecc_dy = '0; ecc_done = 1'b0;
        tick();
        tick();
        // Reset state
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_enable", ecc_enable, 0);
        chk("rst_ecc_rst", ecc_rst, 1);
        chk("rst_ecc_din", ecc_din, 0);
        rst = 1'b0;
        tick();
        chk("idle_s_ready0", s_ready, 1);
        chk("idle_ecc_rst0", ecc_rst, 0);
        chk("idle_busy0", busy, 0);

        // Basic transaction
        load_scalar(192'h1, 0, 163'h1);
        finish_run(163'h5A5, 163'h3C3, 2);
        push_words(192'h5A5);
        push_words(192'h3C3);
        unload(0);

        // Width mask on word 5, input gaps, output backpressure
        load_scalar(192'hFFFFFFFF_55555555_44444444_33333333_22222222_11111111, 3,
                    163'h7_55555555_44444444_33333333_22222222_11111111);
        din_hold = ecc_din;
        s_valid = 1'b1;
        s_data  = 32'hDEADBEEF;
        tick();
        chk("run_s_ready", s_ready, 0);
        chk("run_din_stable", ecc_din, din_hold);
        s_valid = 1'b0;
        finish_run({W{1'b1}}, 163'h2_89ABCDEF_01234567_FEDCBA98_76543210_0F0F0F0F, 1);
        push_words(192'h7_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF);
        push_words(192'h2_89ABCDEF_01234567_FEDCBA98_76543210_0F0F0F0F);
        unload(1);

        // Stale done: ecc_done is still high from the previous run
        chk("stale_done_level", ecc_done, 1);
        load_scalar(192'hA, 0, 163'hA);
        repeat (2) begin
            tick();
            chk("stale_no_mvalid", m_valid, 0);
            chk("stale_enable", ecc_enable, 1);
        end
        finish_run(163'h123, 163'h456, 3);
        push_words(192'h123);
        push_words(192'h456);
        unload(0);

        // Reset in the middle of RUN, then a full transaction
        ecc_done = 1'b0;
        load_scalar(192'h3, 0, 163'h3);
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_enable", ecc_enable, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ecc_rst", ecc_rst, 1);
        chk("midrst_ecc_din", ecc_din, 0);
        rst = 1'b0;
        tick();
        chk("postrst_busy", busy, 0);
        chk("postrst_enable", ecc_enable, 0);
        chk("postrst_s_ready", s_ready, 1);
        load_scalar(192'h0000000E_00000000_00000000_00000000_00000000_00000007, 2,
                    163'h6_00000000_00000000_00000000_00000000_00000007);
        finish_run(163'h4_00000000_00000000_00000000_00000000_00000001,
                   163'h0_00000000_00000000_00000000_ABCDEF01_00000000, 1);
        push_words(192'h4_00000000_00000000_00000000_00000000_00000001);
        push_words(192'h0_00000000_00000000_00000000_ABCDEF01_00000000);
        unload(1);

`ifdef ECC_TIMEOUT_EN
        // Timeout after 50 RUN cycles with done held low
        ecc_done = 1'b0;
        load_scalar(192'h5, 0, 163'h5);
        repeat (49) tick();
        chk("to_cycle50_enable", ecc_enable, 1);
        chk("to_cycle50_err", err, 0);
        tick();
        chk("to_err", err, 1);
        chk("to_busy", busy, 0);
        chk("to_enable", ecc_enable, 0);
        chk("to_s_ready", s_ready, 1);
        repeat (10) begin
            chk("to_no_mvalid", m_valid, 0);
            tick();
        end
        chk("to_err_sticky", err, 1);
        s_valid = 1'b1;
        s_data  = 32'h7;
        tick();
        s_valid = 1'b0;
        chk("to_err_cleared", err, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
